// File: rtl/imem_loader.sv
// imem_loader: streams a program image from a byte source into the
// instruction memory. The image is a 16-bit big-endian word count followed
// by that many big-endian 32-bit words. The words are written one per write
// cycle from word address 0 upward, and busy holds the CPU until the load ends.
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    // Memory depth, widened to 17 bits so a 16-bit header compares cleanly.
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    state_t              state, state_nxt;
    logic [15:0]         count;       // header word count
    logic [ADDR_W-1:0]   word_idx;    // index of the word being assembled
    logic [1:0]          byte_cnt;    // byte position within the current word
    logic [23:0]         asm_q;       // first three bytes of the current word

    logic                accept;
    logic [15:0]         hdr_count;
    logic                word_done;
    logic                last_word;

    assign accept    = rx_valid && rx_ready;
    // Full header as it stands on the edge that takes the low byte.
    assign hdr_count = {count[15:8], rx_data};
    assign word_done = accept && (state == DATA) && (byte_cnt == 2'd3);
    assign last_word = (16'(words_loaded) + 16'd1) == count;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = HDR_HI;
            end
            HDR_HI: begin
                if (accept) state_nxt = HDR_LO;
            end
            HDR_LO: begin
                if (accept) begin
                    if (hdr_count == 16'd0)
                        state_nxt = DONE;
                    else if ({1'b0, hdr_count} > DEPTH)
                        state_nxt = ERR;
                    else
                        state_nxt = DATA;
                end
            end
            DATA: begin
                // busy falls together with the final write strobe.
                if (word_done && last_word) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs. The byte port is open only while loading.
    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            HDR_HI, HDR_LO, DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE:    done  = 1'b1;
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    // Header capture, word assembly and the registered memory write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            asm_q        <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= '0;
        end else begin
            // The strobe lasts exactly the cycle after a word completes.
            wr_en <= word_done;

            if (start && !busy) begin
                word_idx     <= '0;
                byte_cnt     <= '0;
                words_loaded <= '0;
            end

            if (accept && state == HDR_HI) count[15:8] <= rx_data;
            if (accept && state == HDR_LO) count[7:0]  <= rx_data;

            if (accept && state == DATA) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt != 2'd3) begin
                    asm_q <= {asm_q[15:0], rx_data};
                end else begin
                    wr_data      <= {asm_q, rx_data};
                    wr_addr      <= {{(30-ADDR_W){1'b0}}, word_idx, 2'b00};
                    words_loaded <= words_loaded + (ADDR_W+1)'(1);
                    // Hold the index on the final word so a full image
                    // never wraps it back to zero.
                    if (!last_word) word_idx <= word_idx + ADDR_W'(1);
                end
            end
        end
    end

endmodule
